// File: rtl/game_ctrl_fsm_pkg.sv
// Shared types and constants for the game controller.
// States are listed in game_state_t; key codes match the keyboard scan table.
package game_pkg;

  typedef enum logic [2:0] {
    GS_IDLE     = 3'd0,
    GS_START    = 3'd1,
    GS_PLAY     = 3'd2,
    GS_RESPAWN  = 3'd3,
    GS_LEVEL_UP = 3'd4,
    GS_PAUSE    = 3'd5,
    GS_OVER     = 3'd6,
    GS_WON      = 3'd7
  } game_state_t;

  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_P     = 8'd19;

  // Saturating decrement so a hit can never wrap lives below zero.
  function automatic logic [3:0] lives_after_hit(input logic [3:0] lives);
    return (lives > 4'd1) ? (lives - 4'd1) : 4'd0;
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Game controller I/O bundle: key/event inputs and status outputs.
// The bench or host side uses master, the controller uses slave.
interface game_ctrl_fsm_if;

  logic [7:0] keycode;
  logic       player_hit;
  logic       wave_cleared;
  logic       start;
  logic       level_start;
  logic       is_playing;
  logic       is_paused;
  logic       is_finished;
  logic       is_won;
  logic [3:0] lives;
  logic [3:0] level;

  modport master (
    output keycode, player_hit, wave_cleared,
    input  start, level_start, is_playing, is_paused, is_finished, is_won,
           lives, level
  );

  modport slave (
    input  keycode, player_hit, wave_cleared,
    output start, level_start, is_playing, is_paused, is_finished, is_won,
           lives, level
  );

endinterface

// File: rtl/game_ctrl_fsm_key_edge.sv
// Key press detector: flags a new nonzero keycode once; held keys never repeat.
// Suppressed for the first cycle after reset so a key held through reset is ignored.
module key_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode,
  output logic       key_evt,
  output logic [7:0] key_val
);

  logic [7:0] r_key_prev;
  logic       r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_prev <= 8'd0;
      r_armed    <= 1'b0;
    end else begin
      r_key_prev <= keycode;
      r_armed    <= 1'b1;
    end
  end

  assign key_evt = r_armed && (keycode != 8'd0) && (keycode != r_key_prev);
  assign key_val = keycode;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game flow controller: lives, levels, respawn timer and end states.
// Define GAME_PAUSE_EN to add the PAUSE_KEY-toggled PAUSE state.
//
//   state    | meaning
//   IDLE     | waiting for any key press
//   START    | one-cycle new-game setup, start + level_start pulse
//   PLAY     | active play, hits and wave clears processed
//   RESPAWN  | RESPAWN_CYCLES cooldown after a non-fatal hit
//   LEVEL_UP | one-cycle level advance, level_start pulse
//   PAUSE    | play frozen until PAUSE_KEY pressed again
//   OVER     | lives exhausted, waits for START_KEY
//   WON      | last level cleared, waits for START_KEY
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int unsigned NUM_LIVES      = 3,
  parameter int unsigned NUM_LEVELS     = 4,
  parameter int unsigned RESPAWN_CYCLES = 60,
  parameter logic [7:0]  START_KEY      = KEY_SPACE,
  parameter logic [7:0]  PAUSE_KEY      = KEY_P
) (
  input logic          clk,
  input logic          reset,
  game_ctrl_fsm_if.slave bus
);

  localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [3:0]       LIVES_INIT = 4'(NUM_LIVES);
  localparam logic [3:0]       LEVEL_LAST = 4'(NUM_LEVELS - 1);

  localparam logic [2:0] S_IDLE     = GS_IDLE;
  localparam logic [2:0] S_START    = GS_START;
  localparam logic [2:0] S_PLAY     = GS_PLAY;
  localparam logic [2:0] S_RESPAWN  = GS_RESPAWN;
  localparam logic [2:0] S_LEVEL_UP = GS_LEVEL_UP;
  localparam logic [2:0] S_PAUSE    = GS_PAUSE;
  localparam logic [2:0] S_OVER     = GS_OVER;
  localparam logic [2:0] S_WON      = GS_WON;

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic             w_key_evt;
  logic [7:0]       w_key_val;
  logic             w_start_evt;
  logic             w_pause_evt;
  logic [2:0]       r_state, w_state_nxt;
  logic [3:0]       r_lives, w_lives_nxt;
  logic [3:0]       r_level, w_level_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_start, r_level_start;
  logic             r_playing, r_finished, r_won;

  key_edge u_key_edge (
    .clk     (clk),
    .reset   (reset),
    .keycode (bus.keycode),
    .key_evt (w_key_evt),
    .key_val (w_key_val)
  );

  assign w_start_evt = w_key_evt && (w_key_val == START_KEY);
  assign w_pause_evt = PAUSE_EN && w_key_evt && (w_key_val == PAUSE_KEY);

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_level_nxt = r_level;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_key_evt) begin
          w_state_nxt = S_START;
          w_lives_nxt = LIVES_INIT;
          w_level_nxt = 4'd0;
        end
      end
      S_START:    w_state_nxt = S_PLAY;
      // A hit outranks a simultaneous wave clear; the clear is dropped.
      S_PLAY: begin
        if (bus.player_hit) begin
          w_lives_nxt = lives_after_hit(r_lives);
          w_state_nxt = (r_lives > 4'd1) ? S_RESPAWN : S_OVER;
          w_cnt_nxt   = '0;
        end else if (bus.wave_cleared) begin
          if (r_level >= LEVEL_LAST) begin
            w_state_nxt = S_WON;
          end else begin
            w_state_nxt = S_LEVEL_UP;
            w_level_nxt = r_level + 4'd1;
          end
        end else if (w_pause_evt) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_RESPAWN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_PLAY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_LEVEL_UP: w_state_nxt = S_PLAY;
      S_PAUSE: begin
        if (w_pause_evt) w_state_nxt = S_PLAY;
      end
      S_OVER, S_WON: begin
        if (w_start_evt) begin
          w_state_nxt = S_START;
          w_lives_nxt = LIVES_INIT;
          w_level_nxt = 4'd0;
        end
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lives       <= 4'd0;
      r_level       <= 4'd0;
      r_cnt         <= '0;
      r_start       <= 1'b0;
      r_level_start <= 1'b0;
      r_playing     <= 1'b0;
      r_finished    <= 1'b0;
      r_won         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lives       <= w_lives_nxt;
      r_level       <= w_level_nxt;
      r_cnt         <= w_cnt_nxt;
      r_start       <= (w_state_nxt == S_START);
      r_level_start <= (w_state_nxt == S_START) || (w_state_nxt == S_LEVEL_UP);
      r_playing     <= (w_state_nxt == S_PLAY);
      r_finished    <= (w_state_nxt == S_OVER);
      r_won         <= (w_state_nxt == S_WON);
    end
  end

`ifdef GAME_PAUSE_EN
  logic r_paused;

  always_ff @(posedge clk) begin
    if (reset) r_paused <= 1'b0;
    else       r_paused <= (w_state_nxt == S_PAUSE);
  end

  assign bus.is_paused = r_paused;
`else
  assign bus.is_paused = 1'b0;
`endif

  assign bus.start       = r_start;
  assign bus.level_start = r_level_start;
  assign bus.is_playing  = r_playing;
  assign bus.is_finished = r_finished;
  assign bus.is_won      = r_won;
  assign bus.lives       = r_lives;
  assign bus.level       = r_level;

endmodule

// File: doc/game_ctrl_fsm.md
GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

Interface
REQ-001 SHALL have parameter NUM_LIVES, default 3, lives at game start (1..15).
REQ-002 SHALL have parameter NUM_LEVELS, default 4, levels to clear for a win (1..15).
REQ-003 SHALL have parameter RESPAWN_CYCLES, default 60, cycles spent in RESPAWN after a hit (>=1).
REQ-004 SHALL have parameter START_KEY, default 8'd44 (space), restart key from OVER/WON.
REQ-005 SHALL have parameter PAUSE_KEY, default 8'd19 (P), pause toggle key.
REQ-006 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-high reset; keycode input 8 current key, 0 = none.
REQ-007 SHALL have ports: player_hit input 1 one-cycle hit pulse; wave_cleared input 1 one-cycle wave-cleared pulse.
REQ-008 SHALL have ports: start output 1 new-game pulse; level_start output 1 new-level pulse; is_playing output 1; is_paused output 1; is_finished output 1 loss; is_won output 1.
REQ-009 SHALL have ports: lives output 4 remaining lives; level output 4 current level, 0-based.

Function
REQ-010 Key event SHALL mean: keycode nonzero and different from its value in the previous cycle; held keys SHALL NOT repeat.
REQ-011 States SHALL be IDLE, START, PLAY, RESPAWN, LEVEL_UP, PAUSE, OVER, WON; all outputs registered, no combinational input-to-output paths.
REQ-012 IDLE: any key event -> START.
REQ-013 START: one cycle; lives<=NUM_LIVES, level<=0, start=1 and level_start=1 for that cycle; -> PLAY.
REQ-014 PLAY: is_playing=1; player_hit with lives>1 -> lives-1, -> RESPAWN; player_hit with lives==1 -> lives=0, -> OVER.
REQ-015 PLAY: wave_cleared with level==NUM_LEVELS-1 -> WON; otherwise -> LEVEL_UP.
REQ-016 Simultaneous player_hit and wave_cleared in PLAY: hit SHALL win; wave_cleared dropped.
REQ-017 RESPAWN: is_playing=0; counter from 0; after exactly RESPAWN_CYCLES cycles -> PLAY; player_hit/wave_cleared ignored.
REQ-018 LEVEL_UP: one cycle; level+1, level_start=1; lives unchanged; -> PLAY.
REQ-019 OVER: is_finished=1; WON: is_won=1; key event equal to START_KEY -> START; other keys ignored.
REQ-020 start and level_start SHALL be exactly one cycle wide; is_* flags SHALL be mutually exclusive.
REQ-021 lives SHALL never underflow below 0; level SHALL never exceed NUM_LEVELS-1.

Reset
REQ-022 Reset SHALL force IDLE, all flags/pulses 0, lives=0, level=0, respawn counter 0, key history 0, on the next clk edge from any state, including mid-RESPAWN.
REQ-023 A key held through reset release SHALL NOT create a key event in the first cycle after reset.

Configuration
REQ-024 Macro GAME_PAUSE_EN defined: PAUSE_KEY event in PLAY -> PAUSE (is_paused=1, is_playing=0, hit/wave ignored); PAUSE_KEY event in PAUSE -> PLAY; lives/level/counter frozen.
REQ-025 GAME_PAUSE_EN undefined: no PAUSE state, is_paused tied 0, PAUSE_KEY treated as ordinary key.

Structure
REQ-026 Package game_pkg SHALL hold the state enum game_state_t and key constants KEY_SPACE=8'd44, KEY_P=8'd19.
REQ-027 Sub-module key_edge SHALL implement REQ-010/REQ-023 (keycode in, key_evt and key_val out); FSM and counters stay in game_ctrl_fsm.

Verification
REQ-028 Reset, keycode 8'd4 one cycle -> start and level_start pulse 1 cycle, lives=3, level=0, is_playing=1 next cycle.
REQ-029 In PLAY, three player_hit pulses spaced >60 cycles -> lives 2,1,0; RESPAWN lasts exactly 60 cycles twice; third hit -> is_finished=1.
REQ-030 In PLAY, wave_cleared x4 -> level 1,2,3 with level_start pulses, fourth -> is_won=1, level=3.
REQ-031 player_hit and wave_cleared same cycle at lives=2 -> lives=1, level unchanged, RESPAWN entered.
REQ-032 In OVER, keycode 8'd4 -> no change; keycode 8'd44 held 10 cycles -> exactly one start pulse, lives=3.
REQ-033 GAME_PAUSE_EN: keycode 8'd19 in PLAY -> is_paused=1; player_hit ignored; release and re-press 8'd19 -> PLAY, lives unchanged.
